// File: rtl/dma_pkg.sv
// Shared definitions for the multi-channel DMA engine: register offsets,
// CTRL bit positions, FSM encoding and the memory access size code.
package dma_pkg;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_BUSY  = 1;
    localparam int CTRL_DONE  = 2;
    localparam int CTRL_ABORT = 3;

    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_STEP = 3'd4
    } dma_state_e;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int dma_ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin picker: first requesting channel at or after ptr, wrapping.
// Returns a one-hot grant (all zero when nothing requests) and its index.
module dma_rr_arbiter
    import dma_pkg::*;
#(
    parameter  int NUM_CH = 2,
    localparam int CH_W   = dma_ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant_oh,
    output logic [CH_W-1:0]   grant_idx
);

    logic [CH_W-1:0] cand;
    logic            found;

    // Scan channels starting from the pointer and stop at the first request.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = CH_W'((int'(ptr) + i) % NUM_CH);
            if (!found && req[cand]) begin
                found           = 1'b1;
                grant_idx       = cand;
                grant_oh[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_mc_engine.sv
// Multi-channel memory-to-memory DMA engine.
// Holds the per-channel register file, the copy FSM and the memory datapath.
// Optional feature macro: DMA_ABORT_EN (adds CTRL[3] abort request).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no channel busy, memory port quiet
// ARB     | pick next busy channel round-robin, advance pointer
// RD      | read one word from SRC of granted channel, wait mem_ready
// WR      | write latched word to DST of granted channel, wait mem_ready
// STEP    | advance SRC/DST, decrement LEN, retire channel when finished
module dma_mc_engine
    import dma_pkg::*;
#(
    parameter  int NUM_CH = 2,
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    parameter  int LEN_W  = 12,
    localparam int CH_W   = dma_ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_en,
    input  logic              cfg_wr,
    input  logic [CH_W+1:0]   cfg_addr,
    input  logic [ADDR_W-1:0] cfg_wdata,
    output logic [ADDR_W-1:0] cfg_rdata,
    output logic              mem_req,
    output logic              mem_rd_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [NUM_CH-1:0] irq
);

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

    logic [ADDR_W-1:0] src_q [NUM_CH];
    logic [ADDR_W-1:0] dst_q [NUM_CH];
    logic [LEN_W-1:0]  len_q [NUM_CH];
    logic [NUM_CH-1:0] busy_q;
    logic [NUM_CH-1:0] done_q;
`ifdef DMA_ABORT_EN
    logic [NUM_CH-1:0] abort_pend_q;
    logic              abort_hit;
    logic              arb_abort;
`endif

    dma_state_e        state_q, state_d;
    logic [CH_W-1:0]   rr_ptr_q;
    logic [CH_W-1:0]   rr_next;
    logic [CH_W-1:0]   cur_ch_q;
    logic [NUM_CH-1:0] cur_oh;
    logic [DATA_W-1:0] rdata_q;

    logic [NUM_CH-1:0] grant_oh;
    logic [CH_W-1:0]   grant_idx;

    logic              arb_fire;
    logic              rd_latch;
    logic              step_fire;
    logic              step_done;
    logic [NUM_CH-1:0] fin_mask;

    logic [CH_W-1:0]   cfg_ch;
    logic [1:0]        cfg_reg;
    logic              cfg_ch_ok;
    logic [3:0]        ctrl_rd;
    logic [ADDR_W-1:0] rd_mux;

    assign cfg_ch    = cfg_addr[CH_W+1:2];
    assign cfg_reg   = cfg_addr[1:0];
    assign cfg_ch_ok = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));

    assign mem_size  = MEM_SIZE_WORD;
    assign irq       = done_q;

    assign cur_oh    = NUM_CH'(1) << cur_ch_q;
    assign rr_next   = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    assign fin_mask  = step_done ? cur_oh : '0;

`ifdef DMA_ABORT_EN
    assign step_done = (len_q[cur_ch_q] == LEN_W'(1)) || abort_pend_q[cur_ch_q];
    assign abort_hit = |(grant_oh & abort_pend_q);
`else
    assign step_done = (len_q[cur_ch_q] == LEN_W'(1));
`endif

    dma_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req       (busy_q),
        .ptr       (rr_ptr_q),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and memory port drive; outputs come straight from registers
    // that cannot change during an access, so they stay stable while stalled.
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_rd_wr = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        arb_fire  = 1'b0;
        rd_latch  = 1'b0;
        step_fire = 1'b0;
`ifdef DMA_ABORT_EN
        arb_abort = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|busy_q) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (|grant_oh) begin
                    arb_fire = 1'b1;
`ifdef DMA_ABORT_EN
                    if (abort_hit) begin
                        arb_abort = 1'b1;
                        state_d   = ST_ARB;
                    end else begin
                        state_d   = ST_RD;
                    end
`else
                    state_d = ST_RD;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                mem_req  = 1'b1;
                mem_addr = src_q[cur_ch_q];
                if (mem_ready) begin
                    rd_latch = 1'b1;
                    state_d  = ST_WR;
                end
            end
            ST_WR: begin
                mem_req   = 1'b1;
                mem_rd_wr = 1'b1;
                mem_addr  = dst_q[cur_ch_q];
                mem_wdata = rdata_q;
                if (mem_ready) state_d = ST_STEP;
            end
            ST_STEP: begin
                step_fire = 1'b1;
                state_d   = (|(busy_q & ~fin_mask)) ? ST_ARB : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // CTRL readback image for the addressed channel.
    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_BUSY] = busy_q[cfg_ch];
        ctrl_rd[CTRL_DONE] = done_q[cfg_ch];
`ifdef DMA_ABORT_EN
        ctrl_rd[CTRL_ABORT] = abort_pend_q[cfg_ch];
`endif
    end

    // Config read mux; SRC/DST/LEN are the live working values.
    always_comb begin
        rd_mux = '0;
        if (cfg_ch_ok) begin
            case (cfg_reg)
                REG_SRC:  rd_mux = src_q[cfg_ch];
                REG_DST:  rd_mux = dst_q[cfg_ch];
                REG_LEN:  rd_mux = ADDR_W'(len_q[cfg_ch]);
                REG_CTRL: rd_mux = ADDR_W'(ctrl_rd);
                default:  rd_mux = '0;
            endcase
        end
    end

    // Register file and engine updates; engine writes come last so a done
    // set by the engine wins over a W1C clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                src_q[i] <= '0;
                dst_q[i] <= '0;
                len_q[i] <= '0;
            end
            busy_q    <= '0;
            done_q    <= '0;
`ifdef DMA_ABORT_EN
            abort_pend_q <= '0;
`endif
            rr_ptr_q  <= '0;
            cur_ch_q  <= '0;
            rdata_q   <= '0;
            cfg_rdata <= '0;
        end else begin
            if (cfg_en && cfg_wr && cfg_ch_ok) begin
                case (cfg_reg)
                    REG_SRC: if (!busy_q[cfg_ch]) src_q[cfg_ch] <= cfg_wdata;
                    REG_DST: if (!busy_q[cfg_ch]) dst_q[cfg_ch] <= cfg_wdata;
                    REG_LEN: if (!busy_q[cfg_ch]) len_q[cfg_ch] <= cfg_wdata[LEN_W-1:0];
                    REG_CTRL: begin
                        if (cfg_wdata[CTRL_DONE]) done_q[cfg_ch] <= 1'b0;
                        if (cfg_wdata[CTRL_START] && !busy_q[cfg_ch]) begin
                            if (len_q[cfg_ch] == '0) done_q[cfg_ch] <= 1'b1;
                            else                     busy_q[cfg_ch] <= 1'b1;
                        end
`ifdef DMA_ABORT_EN
                        if (cfg_wdata[CTRL_ABORT] && busy_q[cfg_ch])
                            abort_pend_q[cfg_ch] <= 1'b1;
`endif
                    end
                    default: ;
                endcase
            end

            if (cfg_en && !cfg_wr) cfg_rdata <= rd_mux;

            if (arb_fire) begin
                rr_ptr_q <= rr_next;
                cur_ch_q <= grant_idx;
            end

`ifdef DMA_ABORT_EN
            // Abort caught between words: channel retires without an access.
            if (arb_abort) begin
                busy_q[grant_idx]       <= 1'b0;
                done_q[grant_idx]       <= 1'b1;
                abort_pend_q[grant_idx] <= 1'b0;
            end
`endif

            if (rd_latch) rdata_q <= mem_rdata;

            if (step_fire) begin
                src_q[cur_ch_q] <= src_q[cur_ch_q] + STRIDE;
                dst_q[cur_ch_q] <= dst_q[cur_ch_q] + STRIDE;
                len_q[cur_ch_q] <= len_q[cur_ch_q] - LEN_W'(1);
                if (step_done) begin
                    busy_q[cur_ch_q] <= 1'b0;
                    done_q[cur_ch_q] <= 1'b1;
`ifdef DMA_ABORT_EN
                    abort_pend_q[cur_ch_q] <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_mc_engine.sv
// Self-checking bench for dma_mc_engine (NUM_CH=2, 32-bit words).
// Expected memory accesses are queued when a transfer is set up and
// compared by a monitor as the engine performs them.
module tb_dma_mc_engine;

    localparam logic [1:0] R_SRC  = 2'd0;
    localparam logic [1:0] R_DST  = 2'd1;
    localparam logic [1:0] R_LEN  = 2'd2;
    localparam logic [1:0] R_CTRL = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_en;
    logic        cfg_wr;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        mem_req;
    logic        mem_rd_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [1:0]  irq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t exp_q[$];
    acc_t mon_e;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_pat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    assign mem_rdata = mem_pat(mem_addr);

    dma_mc_engine #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .LEN_W(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_en    (cfg_en),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .mem_req   (mem_req),
        .mem_rd_wr (mem_rd_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_size  (mem_size),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .irq       (irq)
    );

    // Scoreboard: every accepted access must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && mem_req && mem_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL mem_unexpected got rw=%0d addr=%h wdata=%h required no access",
                         mem_rd_wr, mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_rd_wr !== mon_e.wr || mem_addr !== mon_e.addr ||
                    (mon_e.wr && mem_wdata !== mon_e.data) || mem_size !== 2'b10) begin
                    failures++;
                    $display("FAIL mem_access got rw=%0d addr=%h wdata=%h size=%b required rw=%0d addr=%h wdata=%h size=10",
                             mem_rd_wr, mem_addr, mem_wdata, mem_size, mon_e.wr, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic push_words(input logic [31:0] src, input logic [31:0] dst, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{1'b0, src + 32'(4 * i), 32'h0});
            exp_q.push_back('{1'b1, dst + 32'(4 * i), mem_pat(src + 32'(4 * i))});
        end
    endtask

    task automatic cfg_write(input int ch, input logic [1:0] rg, input logic [31:0] d);
        @(posedge clk); #1;
        cfg_en    = 1'b1;
        cfg_wr    = 1'b1;
        cfg_addr  = {ch[0], rg};
        cfg_wdata = d;
        @(posedge clk); #1;
        cfg_en    = 1'b0;
        cfg_wr    = 1'b0;
    endtask

    task automatic cfg_read(input int ch, input logic [1:0] rg, output logic [31:0] d);
        @(posedge clk); #1;
        cfg_en   = 1'b1;
        cfg_wr   = 1'b0;
        cfg_addr = {ch[0], rg};
        @(posedge clk); #1;
        cfg_en   = 1'b0;
        d        = cfg_rdata;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_irq(input logic [1:0] mask, input int budget, output int cyc, output bit to);
        cyc = 0;
        to  = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if ((irq & mask) == mask) begin
                to = 1'b0;
                break;
            end
            cyc++;
        end
    endtask

    task automatic wait_access(input logic rw, input logic [31:0] a, input int budget, output bit to);
        to = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (mem_req && mem_rd_wr == rw && mem_addr == a) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_rd_wr, mem_addr, mem_wdata, irq, cfg_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got req=%b rw=%b addr=%h wdata=%h irq=%b rdata=%h required all zero",
                     mem_req, mem_rd_wr, mem_addr, mem_wdata, irq, cfg_rdata);
        end
        for (int ch = 0; ch < 2; ch++) begin
            for (int r = 0; r < 4; r++) begin
                cfg_read(ch, 2'(r), d);
                checks++;
                if (d !== 32'h0) begin
                    failures++;
                    $display("FAIL reset_reg ch%0d reg%0d got=%h required=0", ch, r, d);
                end
            end
        end
    endtask

    task automatic test_single();
        int cyc;
        bit to;
        logic [31:0] d;
        mem_ready = 1'b1;
        cfg_write(0, R_SRC, 32'h100);
        cfg_write(0, R_DST, 32'h200);
        cfg_write(0, R_LEN, 32'd3);
        push_words(32'h100, 32'h200, 3);
        cfg_write(0, R_CTRL, 32'h1);
        wait_irq(2'b01, 100, cyc, to);
        // one IDLE->ARB cycle, then ARB/RD/WR/STEP per word
        checks++;
        if (to || cyc != 13) begin
            failures++;
            $display("FAIL single_latency got cycles=%0d timeout=%0d required=13", cyc, to);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL single_pending got=%0d required=0", exp_q.size());
        end
        cfg_read(0, R_SRC, d);
        checks++;
        if (d !== 32'h10C) begin failures++; $display("FAIL single_src got=%h required=10c", d); end
        cfg_read(0, R_DST, d);
        checks++;
        if (d !== 32'h20C) begin failures++; $display("FAIL single_dst got=%h required=20c", d); end
        cfg_read(0, R_LEN, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL single_len got=%h required=0", d); end
        cfg_read(0, R_CTRL, d);
        checks++;
        if (d !== 32'h4) begin failures++; $display("FAIL single_ctrl got=%h required=4", d); end
        cfg_write(0, R_CTRL, 32'h4);
        @(negedge clk);
        checks++;
        if (irq !== 2'b00) begin failures++; $display("FAIL single_w1c got irq=%b required=00", irq); end
    endtask

    task automatic test_two_ch();
        int cyc;
        bit to;
        do_reset();
        mem_ready = 1'b1;
        cfg_write(0, R_SRC, 32'h1000);
        cfg_write(0, R_DST, 32'h2000);
        cfg_write(0, R_LEN, 32'd2);
        cfg_write(1, R_SRC, 32'h3000);
        cfg_write(1, R_DST, 32'h4000);
        cfg_write(1, R_LEN, 32'd2);
        push_words(32'h1000, 32'h2000, 1);
        push_words(32'h3000, 32'h4000, 1);
        push_words(32'h1004, 32'h2004, 1);
        push_words(32'h3004, 32'h4004, 1);
        cfg_write(0, R_CTRL, 32'h1);
        cfg_write(1, R_CTRL, 32'h1);
        wait_irq(2'b11, 100, cyc, to);
        checks++;
        if (to) begin failures++; $display("FAIL two_ch_irq got irq=%b required=11", irq); end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL two_ch_pending got=%0d required=0", exp_q.size());
        end
        cfg_write(0, R_CTRL, 32'h4);
        cfg_write(1, R_CTRL, 32'h4);
    endtask

    task automatic test_stall();
        int cyc;
        bit to;
        logic [31:0] d;
        cfg_write(0, R_SRC, 32'h500);
        cfg_write(0, R_DST, 32'h600);
        cfg_write(0, R_LEN, 32'd2);
        push_words(32'h500, 32'h600, 2);
        mem_ready = 1'b0;
        cfg_write(0, R_CTRL, 32'h1);
        wait_access(1'b0, 32'h500, 20, to);
        checks++;
        if (to) begin failures++; $display("FAIL stall_start got no read request required read at 500"); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({mem_req, mem_rd_wr, mem_addr} !== {1'b1, 1'b0, 32'h500}) begin
                failures++;
                $display("FAIL stall_hold cyc%0d got req=%b rw=%b addr=%h required req=1 rw=0 addr=500",
                         k, mem_req, mem_rd_wr, mem_addr);
            end
        end
        // SRC write while busy must be dropped
        cfg_write(0, R_SRC, 32'hFFF0);
        @(posedge clk); #1 mem_ready = 1'b1;
        wait_irq(2'b01, 100, cyc, to);
        checks++;
        if (to || exp_q.size() != 0) begin
            failures++;
            $display("FAIL stall_done got timeout=%0d pending=%0d required 0 and 0", to, exp_q.size());
        end
        cfg_read(0, R_SRC, d);
        checks++;
        if (d !== 32'h508) begin failures++; $display("FAIL stall_src got=%h required=508", d); end
        cfg_write(0, R_CTRL, 32'h4);
    endtask

    task automatic test_len_zero();
        bit to;
        logic [31:0] d;
        cfg_write(1, R_LEN, 32'd0);
        cfg_write(1, R_CTRL, 32'h1);
        checks++;
        if (irq[1] !== 1'b1) begin failures++; $display("FAIL len0_done got=%b required=1", irq[1]); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0) begin failures++; $display("FAIL len0_noreq got=%b required=0", mem_req); end
        end
        cfg_read(1, R_CTRL, d);
        checks++;
        if (d !== 32'h4) begin failures++; $display("FAIL len0_ctrl got=%h required=4", d); end
        cfg_write(1, R_CTRL, 32'h4);

        // W1C landing in the same cycle the engine sets done
        mem_ready = 1'b1;
        cfg_write(0, R_SRC, 32'h700);
        cfg_write(0, R_DST, 32'h800);
        cfg_write(0, R_LEN, 32'd1);
        push_words(32'h700, 32'h800, 1);
        cfg_write(0, R_CTRL, 32'h1);
        wait_access(1'b1, 32'h800, 20, to);
        checks++;
        if (to) begin failures++; $display("FAIL race_wr got no write required write at 800"); end
        cfg_write(0, R_CTRL, 32'h4);
        checks++;
        if (irq !== 2'b01) begin failures++; $display("FAIL race_done got irq=%b required=01", irq); end
        cfg_write(0, R_CTRL, 32'h4);
        checks++;
        if (irq !== 2'b00) begin failures++; $display("FAIL race_clear got irq=%b required=00", irq); end
    endtask

    task automatic test_reset_mid();
        bit to;
        logic [31:0] d;
        mem_ready = 1'b1;
        cfg_write(0, R_SRC, 32'h900);
        cfg_write(0, R_DST, 32'hA00);
        cfg_write(0, R_LEN, 32'd4);
        push_words(32'h900, 32'hA00, 4);
        cfg_write(0, R_CTRL, 32'h1);
        wait_access(1'b0, 32'h904, 40, to);
        checks++;
        if (to) begin failures++; $display("FAIL rstmid_rd2 got no read required read at 904"); end
        @(posedge clk); #1 mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_rd_wr, mem_addr} !== {1'b1, 1'b1, 32'hA04}) begin
            failures++;
            $display("FAIL rstmid_wr2 got req=%b rw=%b addr=%h required req=1 rw=1 addr=a04",
                     mem_req, mem_rd_wr, mem_addr);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({mem_req, mem_rd_wr, mem_addr, mem_wdata, irq} !== '0) begin
            failures++;
            $display("FAIL rstmid_out got req=%b rw=%b addr=%h wdata=%h irq=%b required all zero",
                     mem_req, mem_rd_wr, mem_addr, mem_wdata, irq);
        end
        reset     = 1'b0;
        mem_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            cfg_read(0, 2'(r), d);
            checks++;
            if (d !== 32'h0) begin failures++; $display("FAIL rstmid_reg%0d got=%h required=0", r, d); end
        end
        checks++;
        if (exp_q.size() != 5) begin
            failures++;
            $display("FAIL rstmid_abandoned got pending=%0d required=5", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_abort();
        int cyc;
        bit to;
        logic [31:0] d;
        mem_ready = 1'b1;
        cfg_write(0, R_SRC, 32'hB00);
        cfg_write(0, R_DST, 32'hC00);
`ifdef DMA_ABORT_EN
        cfg_write(0, R_LEN, 32'd8);
        push_words(32'hB00, 32'hC00, 2);
`else
        cfg_write(0, R_LEN, 32'd3);
        push_words(32'hB00, 32'hC00, 3);
`endif
        cfg_write(0, R_CTRL, 32'h1);
        wait_access(1'b0, 32'hB04, 40, to);
        checks++;
        if (to) begin failures++; $display("FAIL abort_rd2 got no read required read at b04"); end
        cfg_write(0, R_CTRL, 32'h8);
`ifndef DMA_ABORT_EN
        cfg_read(0, R_CTRL, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL abort_ignored_ctrl got=%h required=2", d); end
`endif
        wait_irq(2'b01, 100, cyc, to);
        checks++;
        if (to || exp_q.size() != 0) begin
            failures++;
            $display("FAIL abort_done got timeout=%0d pending=%0d required 0 and 0", to, exp_q.size());
        end
        cfg_read(0, R_LEN, d);
`ifdef DMA_ABORT_EN
        checks++;
        if (d !== 32'd6) begin failures++; $display("FAIL abort_len got=%h required=6", d); end
        cfg_read(0, R_SRC, d);
        checks++;
        if (d !== 32'hB08) begin failures++; $display("FAIL abort_src got=%h required=b08", d); end
`else
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL abort_ignored_len got=%h required=0", d); end
`endif
        cfg_read(0, R_CTRL, d);
        checks++;
        if (d !== 32'h4) begin failures++; $display("FAIL abort_ctrl got=%h required=4", d); end
        cfg_write(0, R_CTRL, 32'h4);
    endtask

    initial begin
        reset     = 1'b1;
        cfg_en    = 1'b0;
        cfg_wr    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        test_reset();
        test_single();
        test_two_ch();
        test_stall();
        test_len_zero();
        test_reset_mid();
        test_abort();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
